// File: rtl/load_store_unit.sv
// Memory-access stage: turns an EX-stage effective address into a single
// word-aligned bus transaction and returns the extended load result.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  lsu_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            strb;
    logic [DATA_WIDTH-1:0] wdata;
  } bus_t;

  state_t                state_q, state_d;
  bus_t                  bus_q, bus_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] ld_q, ld_d;
  logic                  err_q, err_d;

  logic                  is_ld;
  logic                  is_st;
  logic                  any_req;
  logic                  f3_ok;
  logic                  aligned;
  logic                  legal;
  logic [3:0]            st_strb;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] rd_ext;

  assign is_ld   = mem_read & ~mem_write;
  assign is_st   = mem_write & ~mem_read;
  assign any_req = mem_read | mem_write;

  always_comb begin
    f3_ok = 1'b0;
    if (is_ld)
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010,
                             3'b100, 3'b101};
    else if (is_st)
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
  end

  always_comb begin
    aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign legal = f3_ok & aligned;

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << addr[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_strb  = 4'b0011 << addr[1:0];
        st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = store_data;
      end
    endcase
  end

  assign rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
  assign rd_half = off_q[1] ? mem_rdata[31:16]
                            : mem_rdata[15:0];

  always_comb begin
    rd_ext = mem_rdata;
    case (f3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'b0, rd_byte};
      3'b101:  rd_ext = {16'b0, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    off_d   = off_q;
    f3_d    = f3_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus_d = '0;
        unique case (1'b1)
          !any_req: begin
            bus_d = '0;
          end
          legal: begin
            bus_d.req   = 1'b1;
            bus_d.we    = is_st;
            bus_d.addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
            bus_d.strb  = is_st ? st_strb : 4'b0000;
            bus_d.wdata = is_st ? st_wdata : '0;
            off_d       = addr[1:0];
            f3_d        = funct3;
            cnt_d       = '0;
            state_d     = BUSY;
          end
          default: begin
            err_d   = 1'b1;
            ld_d    = '0;
            state_d = DONE;
          end
        endcase
      end
      BUSY: begin
        if (mem_ready) begin
          if (!bus_q.we)
            ld_d = rd_ext;
          bus_d   = '0;
          state_d = DONE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          bus_d   = '0;
          err_d   = 1'b1;
          ld_d    = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        bus_d   = '0;
        state_d = IDLE;
      end
      default: begin
        bus_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bus_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      cnt_q   <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
    end
  end

  assign stall     = ((state_q == IDLE) & any_req) |
                     (state_q == BUSY);
  assign done      = (state_q == DONE);
  assign lsu_err   = err_q;
  assign load_data = ld_q;
  assign mem_req   = bus_q.req;
  assign mem_we    = bus_q.we;
  assign mem_addr  = bus_q.addr;
  assign mem_wstrb = bus_q.strb;
  assign mem_wdata = bus_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized check of load_store_unit against a byte-level memory model
// plus the directed scenarios: alignment, extension, lanes, timeout, reset.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, done, lsu_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall(stall), .done(done), .load_data(load_data),
    .lsu_err(lsu_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ram [0:255];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] exp_ld;

  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_strb;
  logic        cap_unstable;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    ram[a[9:2]] = w;
    for (int k = 0; k < 4; k++)
      ref_mem[int'(a & 32'h3FC) + k] = w[8*k +: 8];
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic is_legal(input logic rd, input logic wr,
                                    input logic [2:0] f3,
                                    input logic [31:0] a);
    int n;
    if (rd == wr) return 1'b0;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (wr && f3 > 3'd2) return 1'b0;
    n = size_of(f3);
    return (int'(a) % n) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] a);
    int n;
    longint v;
    n = size_of(f3);
    v = 0;
    for (int k = n - 1; k >= 0; k--)
      v = v * 256 + longint'(ref_mem[int'(a & 32'h3FF) + k]);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd);
    int n;
    n = size_of(f3);
    for (int k = 0; k < n; k++)
      ref_mem[int'(a & 32'h3FF) + k] = sd[8*k +: 8];
  endtask

  task automatic do_access(input logic rd, input logic wr,
                           input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input int lat,
                           output logic got_err,
                           output logic [31:0] got_ld,
                           output int total, output int reqs,
                           output int stalls, output logic done_stall);
    int busy;
    logic seen;
    busy = 0; seen = 1'b0; total = -1; reqs = 0; stalls = 0;
    got_err = 1'b0; got_ld = '0; done_stall = 1'b0;
    cap_unstable = 1'b0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3;
    addr = a; store_data = sd; mem_ready = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      #1;
      if (done) begin
        seen = 1'b1;
        got_err = lsu_err;
        got_ld = load_data;
        done_stall = stall;
        total = n + 1;
      end else begin
        if (stall) stalls++;
        if (mem_req) begin
          if (reqs == 0) begin
            cap_addr = mem_addr; cap_we = mem_we;
            cap_strb = mem_wstrb; cap_wdata = mem_wdata;
          end else if (cap_addr !== mem_addr || cap_we !== mem_we ||
                       cap_strb !== mem_wstrb ||
                       cap_wdata !== mem_wdata) begin
            cap_unstable = 1'b1;
          end
          reqs++;
          if (busy == lat) begin
            mem_ready = 1'b1;
            mem_rdata = ram[mem_addr[9:2]];
            if (mem_we)
              for (int k = 0; k < 4; k++)
                if (mem_wstrb[k])
                  ram[mem_addr[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
          end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
          end
          busy++;
        end else begin
          mem_ready = 1'b0;
        end
        @(negedge clk);
      end
    end
    mem_read = 1'b0; mem_write = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int lat,
                        output logic [31:0] got_ld);
    logic lg, tmo, exp_err, got_err, dstall;
    int exp_req, total, reqs, stalls;
    lg  = is_legal(rd, wr, f3, a);
    tmo = lg && lat >= TO;
    if (!lg || tmo) begin
      exp_err = 1'b1;
      exp_ld = '0;
    end else begin
      exp_err = 1'b0;
      if (rd) exp_ld = ref_load(f3, a);
      else ref_store(f3, a, sd);
    end
    exp_req = !lg ? 0 : (tmo ? TO : lat + 1);
    do_access(rd, wr, f3, a, sd, lat, got_err, got_ld,
              total, reqs, stalls, dstall);
    chk({tag, ".err"}, 32'(got_err), 32'(exp_err));
    chk({tag, ".ld"}, got_ld, exp_ld);
    chk({tag, ".lat"}, total, exp_req + 2);
    chk({tag, ".req"}, reqs, exp_req);
    chk({tag, ".stall"}, stalls, exp_req + 1);
    chk({tag, ".dstall"}, 32'(dstall), 0);
    if (lg) begin
      chk({tag, ".hold"}, 32'(cap_unstable), 0);
      chk({tag, ".addr"}, cap_addr, a & 32'hFFFF_FFFC);
      chk({tag, ".we"}, 32'(cap_we), 32'(wr));
    end
  endtask

  logic [31:0] v;
  logic        rr, ww;
  logic [2:0]  f;
  logic [31:0] a;
  int          sel, lt;

  initial begin
    rst = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    addr = '0; store_data = '0; mem_rdata = '0; mem_ready = 1'b0;
    for (int w = 0; w < 256; w++) poke(32'(w * 4), $urandom);
    exp_ld = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.req", 32'(mem_req), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.err", 32'(lsu_err), 0);
    chk("rst.ld", load_data, 0);
    chk("rst.strb", 32'(mem_wstrb), 0);
    chk("rst.stall", 32'(stall), 0);
    rst = 1'b1;

    poke(32'h100, 32'hDEADBEEF);
    run_op("lw", 1, 0, 3'b010, 32'h100, 0, 0, v);
    chk("lw.val", v, 32'hDEADBEEF);
    poke(32'h100, 32'h80112233);
    run_op("lb", 1, 0, 3'b000, 32'h103, 0, 1, v);
    chk("lb.val", v, 32'hFFFFFF80);
    run_op("lbu", 1, 0, 3'b100, 32'h103, 0, 0, v);
    chk("lbu.val", v, 32'h00000080);
    poke(32'h100, 32'hABCD0000);
    run_op("lhu", 1, 0, 3'b101, 32'h102, 0, 2, v);
    chk("lhu.val", v, 32'h0000ABCD);
    run_op("sb", 0, 1, 3'b000, 32'h201, 32'h000000A5, 0, v);
    chk("sb.strb", 32'(cap_strb), 32'b0010);
    chk("sb.wdata", cap_wdata, 32'hA5A5A5A5);
    chk("sb.keep_ld", v, 32'h0000ABCD);
    run_op("sh", 0, 1, 3'b001, 32'h202, 32'h00001234, 1, v);
    chk("sh.strb", 32'(cap_strb), 32'b1100);
    chk("sh.wdata", cap_wdata, 32'h12341234);
    run_op("mis_lw", 1, 0, 3'b010, 32'h102, 0, 0, v);
    run_op("mis_sh", 0, 1, 3'b001, 32'h001, 32'h55, 0, v);
    run_op("bad_f3", 0, 1, 3'b100, 32'h010, 0, 0, v);
    run_op("both", 1, 1, 3'b010, 32'h010, 0, 0, v);
    run_op("tmo", 1, 0, 3'b010, 32'h104, 0, 20, v);
    run_op("post_tmo", 1, 0, 3'b010, 32'h104, 0, 0, v);

    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h108; mem_ready = 1'b0;
    @(negedge clk);
    #1 chk("rstmid.busy", 32'(mem_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid.req", 32'(mem_req), 0);
    chk("rstmid.done", 32'(done), 0);
    chk("rstmid.ld", load_data, 0);
    exp_ld = '0;
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rstmid.idle", 32'(stall), 0);
    run_op("rstmid.lw", 1, 0, 3'b010, 32'h108, 0, 1, v);

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      rr = (sel <= 4) || (sel == 9);
      ww = (sel >= 5);
      if ($urandom_range(0, 9) < 8)
        f = rr && !ww ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2));
      else
        f = 3'($urandom_range(0, 7));
      a = $urandom & 32'h3FF;
      if ($urandom_range(0, 3) != 0)
        a = a & ~32'(size_of(f) - 1);
      lt = ($urandom_range(0, 19) == 0) ? 9 : $urandom_range(0, 2);
      run_op("rnd", rr, ww, f, a, $urandom, lt, v);
    end

    for (int w = 0; w < 256; w++)
      chk("ram", ram[w], {ref_mem[4*w+3], ref_mem[4*w+2],
                          ref_mem[4*w+1], ref_mem[4*w]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
